// File: rtl/dpram_port1_arbiter_pkg.sv
// Shared definitions for the port-1 arbiter of the 64x16 dual-port RAM.
//   RAM_AW / RAM_DW : RAM geometry (address / data width)
//   req_idx_t       : requester index encoding (REQ0 = 0, REQ1 = 1)
//   CNT_W, sat_inc  : burst counter width and its saturating increment
package dpram_port1_arbiter_pkg;

  localparam int RAM_AW = 6;
  localparam int RAM_DW = 16;
  localparam int CNT_W  = 4;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_idx_t;

  // Increment that sticks at lim instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    return (v >= lim) ? lim : v + 1'b1;
  endfunction

endpackage

// File: rtl/dpram_port1_arbiter_if.sv
// One requester channel into the RAM port-1 arbiter.
//   req/we/addr/wdata : request side (driven by the requester)
//   gnt               : accepted this cycle (driven by the arbiter)
//   rvalid/rdata      : read return, one cycle after an accepted read
// Modports: master = requester, slave = arbiter.
interface dpram_port1_arbiter_if;
  import dpram_port1_arbiter_pkg::*;

  logic              req;
  logic              we;
  logic [RAM_AW-1:0] addr;
  logic [RAM_DW-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [RAM_DW-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dpram_port1_arbiter_rr2.sv
// Two-way round-robin arbiter with bounded bursts.
//   CLK, RST   : clock, synchronous active-high reset
//   req0/req1  : level requests
//   gnt0/gnt1  : one-hot (or zero) grants, combinational from req and state
// The current owner keeps winning ties for up to MAX_BURST consecutive
// grants; a lone requester is granted every cycle regardless of the count.
module rr2_burst_arbiter
  import dpram_port1_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_BURST);

  req_idx_t         last;
  logic             owned;
  logic [CNT_W-1:0] cnt;

  req_idx_t win;
  logic     any;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    win = REQ0;
    any = !RST && (req0 || req1);
    if (req0 && req1) begin
      // Tie: continue an unbroken burst, otherwise hand over.
      if (owned && (cnt < LIMIT)) win = last;
      else                        win = (last == REQ0) ? REQ1 : REQ0;
    end else if (req1) begin
      win = REQ1;
    end
    gnt0 = any && (win == REQ0);
    gnt1 = any && (win == REQ1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      last  <= REQ1;          // requester 0 wins the first tie
      owned <= 1'b0;
      cnt   <= '0;
    end else if (any) begin
      cnt   <= (win == last && owned) ? sat_inc(cnt, LIMIT) : CNT_W'(1);
      last  <= win;
      owned <= 1'b1;
    end else begin
      owned <= 1'b0;
      cnt   <= '0;
    end
  end

endmodule

// File: rtl/dpram_port1_arbiter.sv
// Shares the write/read port (port 1) of the 64x16 single-clock dual-port
// RAM between two requesters.
//   CLK, RST     : clock, synchronous active-high reset
//   p0, p1       : requester channels (slave side)
//   ram_we/add/di: port-1 command to the RAM, combinational from the grant
//   ram_do       : RAM DO1 (registered address, valid the cycle after)
// Read data returns to the granted requester one cycle after acceptance.
module dpram_port1_arbiter
  import dpram_port1_arbiter_pkg::*;
#(
  parameter int AW        = RAM_AW,
  parameter int DW        = RAM_DW,
  parameter int MAX_BURST = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  dpram_port1_arbiter_if.slave         p0,
  dpram_port1_arbiter_if.slave         p1,
  output logic                         ram_we,
  output logic [AW-1:0]                ram_add,
  output logic [DW-1:0]                ram_di,
  input  logic [DW-1:0]                ram_do
);

  logic gnt0, gnt1;
  logic rd_pend0, rd_pend1;

  rr2_burst_arbiter #(.MAX_BURST(MAX_BURST)) u_arb (
    .CLK  (CLK),
    .RST  (RST),
    .req0 (p0.req),
    .req1 (p1.req),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  assign p0.gnt = gnt0;
  assign p1.gnt = gnt1;

  // Command mux: idle bus is all-zero so the RAM sees no stray write.
  always_comb begin
    ram_we  = 1'b0;
    ram_add = '0;
    ram_di  = '0;
    if (gnt0) begin
      ram_we  = p0.we;
      ram_add = p0.addr;
      ram_di  = p0.wdata;
    end else if (gnt1) begin
      ram_we  = p1.we;
      ram_add = p1.addr;
      ram_di  = p1.wdata;
    end
  end

  // Remember which requester owns the data that DO1 presents next cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_pend0 <= 1'b0;
      rd_pend1 <= 1'b0;
    end else begin
      rd_pend0 <= gnt0 && !p0.we;
      rd_pend1 <= gnt1 && !p1.we;
    end
  end

  // A read accepted just before reset would surface during the reset cycle;
  // masking with RST drops it.
  assign p0.rvalid = rd_pend0 && !RST;
  assign p1.rvalid = rd_pend1 && !RST;
  assign p0.rdata  = p0.rvalid ? ram_do : '0;
  assign p1.rdata  = p1.rvalid ? ram_do : '0;

endmodule

// File: doc/dpram_port1_arbiter.md
Name: dpram_port1_arbiter

Overview:
- Shares the write/read port (port 1) of the 64x16 single-clock dual-port RAM between two requesters.
- Round-robin arbitration with a bounded burst: the current owner keeps the port for up to MAX_BURST consecutive grants while the other requester waits.
- Drives the RAM's port-1 command (we, add1, DI) and routes the registered-address read data (DO1) back to the granted requester one cycle later.
- The RAM's port 2 (read-only) is outside this block and is not arbitrated.

Parameters:
AW, 6, RAM address width
DW, 16, RAM data width
MAX_BURST, 4, max consecutive grants to one requester while the other is waiting; legal range 1..15

Ports:
CLK  input  1  single system clock, rising edge
RST  input  1  synchronous, active-high reset
req0  input  1  requester 0 access request (level, held until granted)
we0  input  1  requester 0: 1=write, 0=read
addr0  input  AW  requester 0 address
wdata0  input  DW  requester 0 write data
gnt0  output  1  requester 0 access accepted this cycle
rvalid0  output  1  requester 0 read data valid
rdata0  output  DW  requester 0 read data
req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1  same as above for requester 1
ram_we  output  1  to RAM we
ram_add  output  AW  to RAM add1
ram_di  output  DW  to RAM DI
ram_do  input  DW  from RAM DO1

Behaviour:
- Interface decision: one clock (CLK); reset is synchronous and active-high (RST).
- Handshake:
  - A request is accepted in the cycle where req_i=1 and gnt_i=1.
  - gnt is combinational from req and the registered state.
  - At most one gnt is high per cycle.
- RAM command is combinational from the granted requester:
  - ram_add = addr_g; ram_di = wdata_g; ram_we = we_g & gnt_g.
  - With no grant: ram_we=0, ram_add=0, ram_di=0.
- Read latency:
  - A read accepted in cycle N gives rvalid_g=1 in cycle N+1.
  - rdata_g = ram_do in that cycle; rdata is forced to 0 whenever its rvalid=0.
  - Writes produce no rvalid.
- Back-to-back accepted reads, from the same or alternating requesters, give one rvalid per cycle with no bubbles.
- Registered state:
  - last: requester granted most recently.
  - owned: a grant occurred in the previous cycle.
  - cnt: consecutive grants to last, 4 bits, saturating at MAX_BURST.
- Grant decision each cycle:
  - No req: no grant; owned<=0; last is kept; cnt<=0.
  - Exactly one req: grant it.
  - Both req, owned=1 and cnt<MAX_BURST: grant last (burst continues).
  - Both req, otherwise: grant the requester that is not last.
- State update on a grant to r:
  - If r==last and owned: cnt<=min(cnt+1, MAX_BURST).
  - Else: cnt<=1.
  - In both cases last<=r and owned<=1.
- Sole requester: a lone requester is granted every cycle regardless of cnt. It keeps counting, saturated. When the other requester arrives it wins at the next tie-break if cnt==MAX_BURST.
- Reset:
  - last<=1, so requester 0 wins the first tie; owned<=0; cnt<=0.
  - rvalid0/1<=0.
  - gnt0/1, ram_we forced 0 during any cycle where RST=1.
- Reset mid-operation: a read accepted in the cycle before RST is asserted is dropped. No rvalid appears after reset.
- MAX_BURST=1 degenerates to strict alternation under contention.
- Write/read collisions with RAM port 2 are the system's responsibility; this block adds no forwarding.

Decomposition:
- Shared package: RAM_AW=6, RAM_DW=16 constants; requester-index encoding (REQ0=0, REQ1=1).
- One natural sub-module: rr2_burst_arbiter. It holds req0/req1 -> gnt0/gnt1, last/owned/cnt, and MAX_BURST.
- The top level keeps the command mux and the rvalid/rdata return path.

Test Plan:
- Reset, then req0 write addr=5 data=16'hA5A5 for one cycle -> gnt0=1 same cycle, ram_we=1 ram_add=5 ram_di=A5A5. Then req0 read addr=5 -> rvalid0=1 next cycle, rdata0=A5A5, rvalid1=0, rdata1=0.
- Both requesters reading continuously from reset, MAX_BURST=4 -> grant pattern 0,0,0,0,1,1,1,1,0... Each rvalid follows its grant by exactly 1 cycle.
- req1 alone for 10 cycles, then req0 joins -> req1 gets 10 grants; on the next cycle gnt0=1, since cnt saturated at 4.
- Interleaved reads: req0 reads addr 1, req1 reads addr 2 on consecutive grants (contents 16'h0011/16'h0022) -> rdata0=0011 then rdata1=0022 on consecutive cycles, with no cross-routing.
- RST asserted the cycle after a read is accepted -> rvalid stays 0, gnt0/1=0 and ram_we=0 during reset. After release, the first tie goes to requester 0.
- Idle cycle mid-burst (both drop req for 1 cycle after 2 grants to req1, then both reassert) -> requester 0 is granted, because owned was cleared and last=1.
